// File: rtl/tt_pipelined_alu_acc.sv
// Registered add/sub/accumulate/saturating-add unit with valid/ready on both sides.
// One result register stage, a running accumulator and a delivered-result counter.
module tt_pipelined_alu_acc #(
  parameter int WIDTH  = 8,
  parameter int SAT_EN = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_sat,
  output logic [WIDTH-1:0] acc_value,
  output logic [CNT_W-1:0] txn_count
);

  localparam logic [1:0] MODE_ADD    = 2'b00;
  localparam logic [1:0] MODE_SUB    = 2'b01;
  localparam logic [1:0] MODE_ACC    = 2'b10;
  localparam logic [1:0] MODE_SATADD = 2'b11;
  localparam int         MSB         = WIDTH - 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The input side may accept whenever the output register is empty or is
  // being drained in the same cycle; a stalled result blocks new operands.
  logic accept;
  logic deliver;

  assign in_ready = rst || !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !rst;
  assign deliver  = out_valid && out_ready;

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic [WIDTH:0]   acc_sum;
  logic             add_ovf;
  logic             sub_ovf;
  logic             acc_ovf;

  assign acc_value = acc_q;

  // A clear in the same cycle as an ACC op makes the op start from zero.
  always_comb begin
    acc_base = acc_clr ? '0 : acc_q;
    add_sum  = {1'b0, in_a} + {1'b0, in_b};
    sub_diff = {1'b0, in_a} - {1'b0, in_b};
    acc_sum  = {1'b0, acc_base} + {1'b0, in_a};
    add_ovf  = (in_a[MSB] == in_b[MSB]) && (add_sum[MSB] != in_a[MSB]);
    sub_ovf  = (in_a[MSB] != in_b[MSB]) && (sub_diff[MSB] != in_a[MSB]);
    acc_ovf  = (acc_base[MSB] == in_a[MSB]) && (acc_sum[MSB] != acc_base[MSB]);
  end

  logic [WIDTH-1:0] res_data;
  logic             res_carry;
  logic             res_ovf;
  logic             res_sat;

  always_comb begin
    res_data  = add_sum[WIDTH-1:0];
    res_carry = add_sum[WIDTH];
    res_ovf   = add_ovf;
    res_sat   = 1'b0;
    case (in_mode)
      MODE_ADD: begin
        res_data  = add_sum[WIDTH-1:0];
        res_carry = add_sum[WIDTH];
        res_ovf   = add_ovf;
      end
      MODE_SUB: begin
        // Bit WIDTH of the zero-extended difference is the unsigned borrow.
        res_data  = sub_diff[WIDTH-1:0];
        res_carry = sub_diff[WIDTH];
        res_ovf   = sub_ovf;
      end
      MODE_ACC: begin
        res_data  = acc_sum[WIDTH-1:0];
        res_carry = acc_sum[WIDTH];
        res_ovf   = acc_ovf;
      end
      MODE_SATADD: begin
        if (SAT_EN != 0) begin
          res_ovf = 1'b0;
          if (add_sum[WIDTH]) begin
            res_data  = '1;
            res_carry = 1'b1;
            res_sat   = 1'b1;
          end
        end
      end
      default: begin
        res_data  = add_sum[WIDTH-1:0];
        res_carry = add_sum[WIDTH];
        res_ovf   = add_ovf;
      end
    endcase
  end

  // Output register: data and flags only change on an accept, so they hold
  // stable through a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      out_sat   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= res_data;
      out_carry <= res_carry;
      out_ovf   <= res_ovf;
      out_sat   <= res_sat;
    end else if (deliver) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (accept && (in_mode == MODE_ACC)) begin
      acc_q <= acc_sum[WIDTH-1:0];
    end else if (acc_clr) begin
      acc_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txn_count <= '0;
    end else if (deliver) begin
      txn_count <= txn_count + CNT_ONE;
    end
  end

endmodule
